mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter TIMEOUT_CYC, default 8: maximum BUSY cycles awaiting mem_done before an access is aborted.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 ex_valid  in  1  execute-stage record is valid; 0 means bubble.
REQ-005 ALU_Out  in  16  execute result; the memory address when an access is requested.
REQ-006 WrData  in  16  store data (registered RT operand).
REQ-007 MemRead_2ff / MemWrt_2ff  in  1 each  load / store request.
REQ-008 PC_2ff  in  16 and nHaltSig_2ff  in  1  sideband; passed through to writeback unmodified.
REQ-009 mem_addr, mem_wdata  out  16 each  and  mem_rd, mem_wr  out  1 each  data-memory request.
REQ-010 mem_rdata  in  16  and  mem_done  in  1  data-memory response; rdata is valid when done=1.
REQ-011 stall_up  out  1  holds the execute stage and everything upstream.
REQ-012 Writeback outputs: wb_valid 1, MemOut 16, ALU_Out_3ff 16, PC_3ff 16, nHaltSig_3ff 1, err 1, and err_sticky 1.

Function
REQ-013 access = ex_valid & (MemRead_2ff | MemWrt_2ff); illegal = access & (ALU_Out[0] | (MemRead_2ff & MemWrt_2ff)).
REQ-014 FSM states are IDLE and BUSY only.
REQ-015 IDLE, no access or illegal: load the WB register at the edge; stall_up=0; no memory request.
REQ-016 IDLE, legal access: latch address, data and op; go to BUSY; stall_up=1 this cycle.
REQ-017 mem_rd/mem_wr pulse for exactly the first BUSY cycle; mem_addr/mem_wdata hold latched values throughout BUSY, 0 in IDLE.
REQ-018 BUSY: stall_up = ~mem_done & (cnt != TIMEOUT_CYC); cnt starts at 1 on BUSY entry and increments each BUSY cycle.
REQ-019 BUSY with mem_done=1: load WB register (MemOut=mem_rdata for loads, 0 for stores); return to IDLE; err=0.
REQ-020 BUSY with cnt==TIMEOUT_CYC and mem_done=0: abort; load WB register with MemOut=0 and err=1; return to IDLE.
REQ-021 mem_done=1 and timeout in the same cycle: mem_done wins.
REQ-022 mem_done seen in IDLE is ignored.
REQ-023 Illegal access: err=1, MemOut=0, wb_valid=1, one-cycle latency, no request issued.
REQ-024 WB register holds its value while stall_up=1, with wb_valid=0 during the stall. wb_valid = registered ex_valid otherwise.
REQ-025 Latency:
- non-memory or illegal: 1 cycle;
- memory access: 1 IDLE cycle, plus the BUSY cycles up to and including the mem_done cycle, plus 1 cycle.
REQ-026 err_sticky sets whenever err is loaded as 1; it clears only on reset.
REQ-027 ALU_Out_3ff, PC_3ff and nHaltSig_3ff carry the values of the record that caused the WB load.

Reset
REQ-028 rst=0 forces, immediately and regardless of clk, FSM=IDLE, cnt=0, and every output and register to 0, including nHaltSig_3ff and err_sticky.
REQ-029 Reset during BUSY abandons the access: no WB load; mem_rd/mem_wr drop immediately.
REQ-030 The first edge after rst rises treats its inputs as a fresh IDLE cycle.

Structure
REQ-031 Shared package mem_stage_pkg holds:
- the state enum {IDLE, BUSY};
- TIMEOUT_CYC default;
- the 16-bit data-width constant.
REQ-032 One sub-module, mem_req_fsm, owns state, cnt, request pulse and stall_up. The WB register lives in the top.
REQ-033 No combinational path from mem_rdata to stall_up; stall_up may depend combinationally on mem_done, state, cnt and access inputs only.

Verification
REQ-034 Non-memory record (ex_valid=1, ALU_Out=16'h1234, rd=wr=0):
- next cycle wb_valid=1, ALU_Out_3ff=16'h1234, err=0;
- stall_up never asserts.
REQ-035 Load at 16'h0040 with memory done on the 3rd BUSY cycle returning 16'hBEEF:
- mem_rd pulses once, mem_addr=16'h0040;
- stall_up is high for 3 cycles;
- the next cycle shows MemOut=16'hBEEF, wb_valid=1.
REQ-036 Store to 16'h0102, data 16'hA5A5, done on the 1st BUSY cycle:
- mem_wr pulses once, mem_wdata=16'hA5A5;
- stall_up is high 1 cycle;
- the next cycle shows wb_valid=1, MemOut=0.
REQ-037 Load to 16'h0003 (odd): no mem_rd; the next cycle shows err=1, err_sticky=1, wb_valid=1, MemOut=0.
REQ-038 TIMEOUT_CYC=4 with mem_done never asserted: after 4 BUSY cycles, err=1 and FSM back in IDLE; the next access issues normally.
REQ-039 rst pulled low during the 2nd BUSY cycle:
- all outputs 0 immediately;
- a late mem_done after reset is ignored;
- no WB load occurs.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory stage.
//   DATA_W          - datapath width of addresses, store data and load data
//   TIMEOUT_CYC_DEF - default number of BUSY cycles allowed before an abort
//   state_t         - request FSM states
package mem_stage_pkg;

    localparam int DATA_W          = 16;
    localparam int TIMEOUT_CYC_DEF = 8;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory bus between the memory stage and the data memory.
//   master: drives mem_addr/mem_wdata/mem_rd/mem_wr, receives mem_rdata/mem_done
//   slave : the memory side of the same bus
interface mem_stage_if
    import mem_stage_pkg::*;
;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_rd;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_done;

    modport master (
        output mem_addr, mem_wdata, mem_rd, mem_wr,
        input  mem_rdata, mem_done
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_rd, mem_wr,
        output mem_rdata, mem_done
    );

endinterface

// File: rtl/mem_req_fsm.sv
// Request sequencer for the memory stage: owns the IDLE/BUSY state, the BUSY
// cycle counter, the one-cycle request pulse and the upstream stall.
//   in : clk, rst (async, active-low), access, illegal, op_rd_in, op_wr_in,
//        addr_in, wdata_in, mem_done
//   out: done_evt / abort_evt (BUSY ends this cycle by completion / timeout),
//        op_rd (latched op is a load), stall_up, mem_rd, mem_wr, mem_addr,
//        mem_wdata
//
// state | meaning
// IDLE  | no access outstanding; legal access is latched at the edge
// BUSY  | access outstanding; waiting for mem_done or the timeout
module mem_req_fsm
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              access,
    input  logic              illegal,
    input  logic              op_rd_in,
    input  logic              op_wr_in,
    input  logic [DATA_W-1:0] addr_in,
    input  logic [DATA_W-1:0] wdata_in,
    input  logic              mem_done,
    output logic              done_evt,
    output logic              abort_evt,
    output logic              op_rd,
    output logic              stall_up,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata
);

    localparam int               CNT_W   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [DATA_W-1:0] addr_q, wdata_q;
    logic              rd_q, wr_q;
    logic              start, stall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (start) begin
                addr_q  <= addr_in;
                wdata_q <= wdata_in;
                rd_q    <= op_rd_in;
                wr_q    <= op_wr_in;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        start     = 1'b0;
        stall     = 1'b0;
        done_evt  = 1'b0;
        abort_evt = 1'b0;
        case (state)
            IDLE: begin
                if (access && !illegal) begin
                    start     = 1'b1;
                    stall     = 1'b1;
                    state_nxt = BUSY;
                    cnt_nxt   = CNT_ONE;
                end
            end
            BUSY: begin
                // Completion is checked first so a response arriving on the
                // timeout cycle is still accepted.
                if (mem_done) begin
                    done_evt  = 1'b1;
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_MAX) begin
                    abort_evt = 1'b1;
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    stall   = 1'b1;
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // cnt is 1 only on the first BUSY cycle, which gives the single pulse.
    assign mem_rd    = (state == BUSY) && (cnt == CNT_ONE) && rd_q;
    assign mem_wr    = (state == BUSY) && (cnt == CNT_ONE) && wr_q;
    assign mem_addr  = (state == BUSY) ? addr_q  : '0;
    assign mem_wdata = (state == BUSY) ? wdata_q : '0;
    assign op_rd     = rd_q;
    // Gated so the stall reads 0 while reset is held, even with an access
    // presented on the inputs.
    assign stall_up  = stall & rst;

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: issues data-memory requests for loads/stores coming
// out of execute, stalls upstream while they are outstanding, and holds the
// writeback register.
//   in : clk, rst (async, active-low), ex_valid, ALU_Out, WrData,
//        MemRead_2ff, MemWrt_2ff, PC_2ff, nHaltSig_2ff
//   bus: mem (mem_stage_if.master)
//   out: stall_up, wb_valid, MemOut, ALU_Out_3ff, PC_3ff, nHaltSig_3ff,
//        err, err_sticky
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic [DATA_W-1:0] ALU_Out,
    input  logic [DATA_W-1:0] WrData,
    input  logic              MemRead_2ff,
    input  logic              MemWrt_2ff,
    input  logic [DATA_W-1:0] PC_2ff,
    input  logic              nHaltSig_2ff,
    mem_stage_if.master       mem,
    output logic              stall_up,
    output logic              wb_valid,
    output logic [DATA_W-1:0] MemOut,
    output logic [DATA_W-1:0] ALU_Out_3ff,
    output logic [DATA_W-1:0] PC_3ff,
    output logic              nHaltSig_3ff,
    output logic              err,
    output logic              err_sticky
);

    logic              access, illegal;
    logic              done_evt, abort_evt, op_rd;
    logic [DATA_W-1:0] wb_mem_out;
    logic              wb_err;

    assign access  = ex_valid & (MemRead_2ff | MemWrt_2ff);
    assign illegal = access & (ALU_Out[0] | (MemRead_2ff & MemWrt_2ff));

    mem_req_fsm #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_req_fsm (
        .clk       (clk),
        .rst       (rst),
        .access    (access),
        .illegal   (illegal),
        .op_rd_in  (MemRead_2ff),
        .op_wr_in  (MemWrt_2ff),
        .addr_in   (ALU_Out),
        .wdata_in  (WrData),
        .mem_done  (mem.mem_done),
        .done_evt  (done_evt),
        .abort_evt (abort_evt),
        .op_rd     (op_rd),
        .stall_up  (stall_up),
        .mem_rd    (mem.mem_rd),
        .mem_wr    (mem.mem_wr),
        .mem_addr  (mem.mem_addr),
        .mem_wdata (mem.mem_wdata)
    );

    // Whenever the WB register loads, it is one of: a completed access,
    // an aborted access, or an IDLE-cycle record (bubble, non-memory, illegal).
    always_comb begin
        wb_mem_out = '0;
        wb_err     = 1'b0;
        if (done_evt) begin
            if (op_rd) wb_mem_out = mem.mem_rdata;
        end else if (abort_evt) begin
            wb_err = 1'b1;
        end else begin
            wb_err = illegal;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_valid     <= 1'b0;
            MemOut       <= '0;
            ALU_Out_3ff  <= '0;
            PC_3ff       <= '0;
            nHaltSig_3ff <= 1'b0;
            err          <= 1'b0;
            err_sticky   <= 1'b0;
        end else if (stall_up) begin
            wb_valid <= 1'b0;
        end else begin
            // Upstream is held during a stall, so the inputs still carry the
            // record that started the access.
            wb_valid     <= ex_valid;
            MemOut       <= wb_mem_out;
            ALU_Out_3ff  <= ALU_Out;
            PC_3ff       <= PC_2ff;
            nHaltSig_3ff <= nHaltSig_2ff;
            err          <= wb_err;
            if (wb_err) err_sticky <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
    import mem_stage_pkg::*;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [15:0] ALU_Out, WrData, PC_2ff;
    logic        MemRead_2ff, MemWrt_2ff, nHaltSig_2ff;
    logic        stall_up, wb_valid, nHaltSig_3ff, err, err_sticky;
    logic [15:0] MemOut, ALU_Out_3ff, PC_3ff;

    mem_stage_if m ();

    mem_stage #(.TIMEOUT_CYC(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .ex_valid     (ex_valid),
        .ALU_Out      (ALU_Out),
        .WrData       (WrData),
        .MemRead_2ff  (MemRead_2ff),
        .MemWrt_2ff   (MemWrt_2ff),
        .PC_2ff       (PC_2ff),
        .nHaltSig_2ff (nHaltSig_2ff),
        .mem          (m),
        .stall_up     (stall_up),
        .wb_valid     (wb_valid),
        .MemOut       (MemOut),
        .ALU_Out_3ff  (ALU_Out_3ff),
        .PC_3ff       (PC_3ff),
        .nHaltSig_3ff (nHaltSig_3ff),
        .err          (err),
        .err_sticky   (err_sticky)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    logic sticky_m = 1'b0;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    // One record through the stage. The model: a legal access stalls for the
    // number of BUSY cycles it occupies (k if mem_done arrives on BUSY cycle
    // k <= TO, else TO), pulses its request once, and writes back rdata for a
    // completed load, 0 otherwise, with err set on illegal or timeout.
    task automatic run_record(input logic ev, input logic [15:0] a, input logic [15:0] wd,
                              input logic rd, input logic wr, input logic [15:0] pc,
                              input logic nh, input int k, input logic [15:0] rdata,
                              input string tag);
        logic        acc, ill, legal, done_ok, exp_err, st;
        logic [15:0] exp_out;
        int          exp_stall, exp_rd, exp_wr;
        int          stalls = 0, rds = 0, wrs = 0, c = 0;
        acc       = ev & (rd | wr);
        ill       = acc & (a[0] | (rd & wr));
        legal     = acc & ~ill;
        done_ok   = legal && (k >= 1) && (k <= TO);
        exp_stall = !legal ? 0 : (done_ok ? k : TO);
        exp_rd    = (legal && rd) ? 1 : 0;
        exp_wr    = (legal && wr) ? 1 : 0;
        exp_err   = ill | (legal & ~done_ok);
        exp_out   = (done_ok && rd) ? rdata : 16'h0000;

        ex_valid = ev; ALU_Out = a; WrData = wd; MemRead_2ff = rd; MemWrt_2ff = wr;
        PC_2ff = pc; nHaltSig_2ff = nh;
        while (1) begin
            // A random mem_done on the IDLE cycle must be ignored.
            m.mem_done  = (c == 0) ? 1'($urandom_range(0, 1)) : (c == k);
            m.mem_rdata = (c == k) ? rdata : 16'($urandom);
            #1;
            st = stall_up;
            if (st) stalls++;
            if (m.mem_rd) rds++;
            if (m.mem_wr) wrs++;
            if (c == 0) begin
                n_checks++;
                if (m.mem_addr !== 16'h0000) begin
                    n_fail++;
                    $display("FAIL %s idle_addr: got %h expected 0000", tag, m.mem_addr);
                end
            end else begin
                n_checks++;
                if (m.mem_addr !== a) begin
                    n_fail++;
                    $display("FAIL %s busy_addr cyc %0d: got %h expected %h", tag, c, m.mem_addr, a);
                end
                n_checks++;
                if (wb_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s wb_valid_in_stall cyc %0d: got %b expected 0", tag, c, wb_valid);
                end
                if (wr) begin
                    n_checks++;
                    if (m.mem_wdata !== wd) begin
                        n_fail++;
                        $display("FAIL %s busy_wdata: got %h expected %h", tag, m.mem_wdata, wd);
                    end
                end
            end
            @(posedge clk); #1;
            if (!st) break;
            c++;
            if (c > 40) begin
                n_fail++;
                $display("FAIL %s stall_bound: got >40 stall cycles expected %0d", tag, exp_stall);
                break;
            end
        end
        m.mem_done = 1'b0;
        sticky_m = sticky_m | exp_err;

        n_checks++;
        if (stalls != exp_stall) begin n_fail++; $display("FAIL %s stall_cycles: got %0d expected %0d", tag, stalls, exp_stall); end
        n_checks++;
        if (rds != exp_rd) begin n_fail++; $display("FAIL %s rd_pulses: got %0d expected %0d", tag, rds, exp_rd); end
        n_checks++;
        if (wrs != exp_wr) begin n_fail++; $display("FAIL %s wr_pulses: got %0d expected %0d", tag, wrs, exp_wr); end
        n_checks++;
        if (wb_valid !== ev) begin n_fail++; $display("FAIL %s wb_valid: got %b expected %b", tag, wb_valid, ev); end
        n_checks++;
        if (err !== exp_err) begin n_fail++; $display("FAIL %s err: got %b expected %b", tag, err, exp_err); end
        n_checks++;
        if (MemOut !== exp_out) begin n_fail++; $display("FAIL %s MemOut: got %h expected %h", tag, MemOut, exp_out); end
        n_checks++;
        if (ALU_Out_3ff !== a) begin n_fail++; $display("FAIL %s ALU_Out_3ff: got %h expected %h", tag, ALU_Out_3ff, a); end
        n_checks++;
        if (PC_3ff !== pc) begin n_fail++; $display("FAIL %s PC_3ff: got %h expected %h", tag, PC_3ff, pc); end
        n_checks++;
        if (nHaltSig_3ff !== nh) begin n_fail++; $display("FAIL %s nHaltSig_3ff: got %b expected %b", tag, nHaltSig_3ff, nh); end
        n_checks++;
        if (err_sticky !== sticky_m) begin n_fail++; $display("FAIL %s err_sticky: got %b expected %b", tag, err_sticky, sticky_m); end
    endtask

    task automatic check_all_zero(input string tag);
        n_checks++;
        if ({stall_up, m.mem_rd, m.mem_wr, wb_valid, err, err_sticky, nHaltSig_3ff} !== 7'b0) begin
            n_fail++;
            $display("FAIL %s ctrl_zero: got %b expected 0000000", tag,
                     {stall_up, m.mem_rd, m.mem_wr, wb_valid, err, err_sticky, nHaltSig_3ff});
        end
        n_checks++;
        if ({m.mem_addr, m.mem_wdata, MemOut, ALU_Out_3ff, PC_3ff} !== 80'h0) begin
            n_fail++;
            $display("FAIL %s data_zero: got %h expected 0", tag,
                     {m.mem_addr, m.mem_wdata, MemOut, ALU_Out_3ff, PC_3ff});
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ex_valid = 1'b1; ALU_Out = 16'h0040; WrData = 16'h1111; MemRead_2ff = 1'b1;
        MemWrt_2ff = 1'b0; PC_2ff = 16'h0100; nHaltSig_2ff = 1'b1;
        m.mem_done = 1'b0; m.mem_rdata = 16'h0000;
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check_all_zero("reset");
        sticky_m = 1'b0;
        ex_valid = 1'b0; MemRead_2ff = 1'b0;
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_non_mem();
        run_record(1'b1, 16'h1234, 16'h0000, 1'b0, 1'b0, 16'h0200, 1'b1, 1, 16'h0, "non_mem");
        run_record(1'b0, 16'h5678, 16'h0000, 1'b1, 1'b0, 16'h0202, 1'b0, 1, 16'h0, "bubble");
    endtask

    task automatic test_load();
        run_record(1'b1, 16'h0040, 16'h0000, 1'b1, 1'b0, 16'h0204, 1'b1, 3, 16'hBEEF, "load");
    endtask

    task automatic test_store();
        run_record(1'b1, 16'h0102, 16'hA5A5, 1'b0, 1'b1, 16'h0206, 1'b1, 1, 16'h7777, "store");
    endtask

    task automatic test_illegal();
        run_record(1'b1, 16'h0003, 16'h0000, 1'b1, 1'b0, 16'h0208, 1'b1, 1, 16'h0, "odd_load");
        run_record(1'b1, 16'h0010, 16'h0000, 1'b1, 1'b1, 16'h020A, 1'b1, 1, 16'h0, "rd_and_wr");
    endtask

    task automatic test_timeout();
        run_record(1'b1, 16'h0080, 16'h0000, 1'b1, 1'b0, 16'h020C, 1'b1, 0, 16'h0, "timeout");
        run_record(1'b1, 16'h0084, 16'h0000, 1'b1, 1'b0, 16'h020E, 1'b1, 2, 16'hCAFE, "after_timeout");
        run_record(1'b1, 16'h0088, 16'h3C3C, 1'b0, 1'b1, 16'h0210, 1'b0, TO, 16'h0, "done_at_timeout");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 80; i++) begin
            logic [15:0] a;
            a = 16'($urandom);
            if ($urandom_range(0, 3) != 0) a[0] = 1'b0;
            run_record(($urandom_range(0, 4) != 0), a, 16'($urandom),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom),
                       1'($urandom_range(0, 1)), $urandom_range(0, TO + 1), 16'($urandom),
                       "random");
        end
    endtask

    task automatic test_reset_busy();
        ex_valid = 1'b1; ALU_Out = 16'h00A0; WrData = 16'h0000; MemRead_2ff = 1'b1;
        MemWrt_2ff = 1'b0; PC_2ff = 16'h0300; nHaltSig_2ff = 1'b1;
        m.mem_done = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #1;
        n_checks++;
        if (m.mem_addr !== 16'h00A0) begin
            n_fail++;
            $display("FAIL rst_busy pre_addr: got %h expected 00a0", m.mem_addr);
        end
        rst = 1'b0;
        #1;
        check_all_zero("rst_busy");
        sticky_m = 1'b0;
        ex_valid = 1'b0; MemRead_2ff = 1'b0; ALU_Out = 16'h0000; PC_2ff = 16'h0000;
        nHaltSig_2ff = 1'b0;
        @(negedge clk) rst = 1'b1;
        m.mem_done = 1'b1; m.mem_rdata = 16'hDEAD;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({wb_valid, err, m.mem_rd, stall_up} !== 4'b0 || MemOut !== 16'h0000) begin
                n_fail++;
                $display("FAIL rst_busy late_done cyc %0d: got valid/err/rd/stall %b MemOut %h expected 0000 0000",
                         i, {wb_valid, err, m.mem_rd, stall_up}, MemOut);
            end
        end
        m.mem_done = 1'b0;
        run_record(1'b1, 16'h00B0, 16'h0000, 1'b1, 1'b0, 16'h0310, 1'b1, 2, 16'h1357, "after_rst");
    endtask

    initial begin
        test_reset();
        test_non_mem();
        test_load();
        test_store();
        test_illegal();
        test_timeout();
        test_back_to_back();
        test_reset_busy();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
